// File: rtl/twowire_dtm_payload_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// twowire_dtm_payload_ctrl
//
// Command/payload controller for the DTM serial comms unit. Each framed command
// from the serial unit is decoded and sized. Write payload bits are shifted in
// and read payload bits are shifted out, LSB first. cmd_payload_end flags the
// last payload bit. The block sequences at most one outstanding bus access.
// Side effects (address update, bus launch, CSR write, sticky flags) commit only
// in the check cycle after the last bit, and only if no parity error is seen.
//
// Build option:
//   DTM_PAYLOAD_AUTO_INCR_EN - implements the AINCR (address auto-increment)
//   CSR bit. When it is undefined, AINCR reads 0, writes to it are ignored, and
//   the address never increments.
//
// Parameters:
//   W_CMD   command width (must match the serial unit)
//   W_ADDR  bus address width, 8..32
//
// Ports:
//   dck              in   DTM clock
//   drst             in   synchronous active-high reset
//   connected        in   link connected; low aborts the payload FSM
//   cmd              in   command, valid with cmd_vld
//   cmd_vld          in   command received with good parity (1-cycle pulse)
//   cmd_payload_end  out  current payload bit is the last one (combinational)
//   parity_err       in   command or write-payload parity failure pulse
//   wdata            in   write payload bit, LSB first
//   wdata_vld        in   wdata valid this cycle
//   rdata            out  read payload bit, LSB first
//   rdata_rdy        in   rdata consumed this cycle
//   bus_req          out  bus request, held until bus_ack
//   bus_write        out  1 = write, 0 = read
//   bus_addr         out  byte address
//   bus_wdata        out  write data
//   bus_ack          in   one-cycle completion
//   bus_rdata        in   read data, valid with bus_ack
//   bus_err          in   error response, valid with bus_ack
// -----------------------------------------------------------------------------
module twowire_dtm_payload_ctrl #(
  parameter int W_CMD  = 4,
  parameter int W_ADDR = 32
) (
  input  logic              dck,
  input  logic              drst,
  input  logic              connected,
  input  logic [W_CMD-1:0]  cmd,
  input  logic              cmd_vld,
  output logic              cmd_payload_end,
  input  logic              parity_err,
  input  logic              wdata,
  input  logic              wdata_vld,
  output logic              rdata,
  input  logic              rdata_rdy,
  output logic              bus_req,
  output logic              bus_write,
  output logic [W_ADDR-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

  localparam logic [W_CMD-1:0] CMD_R_STAT = W_CMD'(1);
  localparam logic [W_CMD-1:0] CMD_R_ADDR = W_CMD'(2);
  localparam logic [W_CMD-1:0] CMD_W_ADDR = W_CMD'(3);
  localparam logic [W_CMD-1:0] CMD_R_DATA = W_CMD'(4);
  localparam logic [W_CMD-1:0] CMD_W_DATA = W_CMD'(5);
  localparam logic [W_CMD-1:0] CMD_W_CSR  = W_CMD'(6);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_DATA  = 2'd1,
    C_CHECK = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [W_CMD-1:0]    cmd_q;
  logic [5:0]          cnt;
  logic [31:0]         wshift;
  logic [31:0]         rshift;
  logic [W_ADDR-1:0]   addr;
  logic [31:0]         rbuf;
  logic                parerr, unkcmd, buserr, busyerr, aincr;
  logic [7:0]          stat;

  // Decode / commit strobes
  logic                load, step, commit, launch_ok;
  logic                launch, launch_write;
  logic [W_ADDR-1:0]   launch_addr;
  logic                addr_we;
  logic [W_ADDR-1:0]   addr_n;
  logic                busy_set, unk_set, csr_we;
  logic [31:0]         rload;
  logic [W_ADDR-1:0]   waddr;
  logic [W_ADDR-1:0]   addr_inc;

  // Index of the last payload bit for a command (payload length - 1).
  function automatic logic [5:0] last_bit(input logic [W_CMD-1:0] c);
    logic [5:0] r;
    unique case (c)
      CMD_R_STAT, CMD_W_CSR:   r = 6'd7;
      CMD_R_ADDR, CMD_W_ADDR:  r = 6'(W_ADDR - 1);
      CMD_R_DATA, CMD_W_DATA:  r = 6'd31;
      default:                 r = 6'd0;
    endcase
    return r;
  endfunction

  assign stat     = {2'b00, parerr, unkcmd, aincr, buserr, busyerr, bus_req};
  assign rdata    = rshift[0];
  // Write bits enter at the MSB, so an N-bit payload ends up left-aligned.
  assign waddr    = wshift[31 -: W_ADDR];
  assign addr_inc = addr + W_ADDR'(4);

  // ---------------------------------------------------------------------------
  // Payload FSM: next state and commit decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n         = state;
    load            = 1'b0;
    step            = (state == C_DATA) && (wdata_vld || rdata_rdy);
    commit          = 1'b0;
    cmd_payload_end = step && (cnt == 6'd0);

    unique case (state)
      C_IDLE:  if (cmd_vld) begin
                 state_n = C_DATA;
                 load    = 1'b1;
               end
      C_DATA:  if (parity_err)                 state_n = C_IDLE;
               else if (step && cnt == 6'd0)   state_n = C_CHECK;
      C_CHECK: begin
                 state_n = C_IDLE;
                 commit  = !parity_err;
               end
      default: state_n = C_IDLE;
    endcase

    // Loss of link drops any payload in progress; bus traffic is unaffected.
    if (!connected) begin
      state_n = C_IDLE;
      load    = 1'b0;
      commit  = 1'b0;
    end
  end

  always_comb begin
    launch_ok    = !bus_req || bus_ack;
    launch       = 1'b0;
    launch_write = 1'b0;
    launch_addr  = addr;
    addr_we      = 1'b0;
    addr_n       = addr;
    busy_set     = 1'b0;
    unk_set      = 1'b0;
    csr_we       = 1'b0;

    if (commit) begin
      unique case (cmd_q)
        CMD_W_ADDR: begin
          if (launch_ok) begin
            // New address plus a prefetch read so R_DATA has data ready.
            launch      = 1'b1;
            launch_addr = waddr;
            addr_we     = 1'b1;
            addr_n      = waddr;
          end else begin
            busy_set = 1'b1;
          end
        end
        CMD_W_DATA: begin
          if (launch_ok) begin
            launch       = 1'b1;
            launch_write = 1'b1;
            launch_addr  = addr;
            addr_we      = aincr;
            addr_n       = addr_inc;
          end else begin
            busy_set = 1'b1;
          end
        end
        CMD_R_DATA: begin
          // The data just shifted out came from rbuf; this read refills it.
          if (launch_ok) begin
            launch      = 1'b1;
            launch_addr = aincr ? addr_inc : addr;
            addr_we     = aincr;
            addr_n      = addr_inc;
          end else begin
            busy_set = 1'b1;
          end
        end
        CMD_W_CSR:              csr_we  = 1'b1;
        CMD_R_STAT, CMD_R_ADDR: ;
        default:                unk_set = 1'b1;
      endcase
    end

    unique case (cmd)
      CMD_R_STAT: rload = 32'(stat);
      CMD_R_ADDR: rload = 32'(addr);
      CMD_R_DATA: rload = rbuf;
      default:    rload = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge dck) begin
    if (drst) state <= C_IDLE;
    else      state <= state_n;
  end

  // ---------------------------------------------------------------------------
  // Payload shifters, bit counter, address register
  // ---------------------------------------------------------------------------
  always_ff @(posedge dck) begin
    if (drst) begin
      cmd_q  <= '0;
      cnt    <= '0;
      wshift <= '0;
      rshift <= '0;
      addr   <= '0;
    end else begin
      if (load) begin
        cmd_q  <= cmd;
        cnt    <= last_bit(cmd);
        rshift <= rload;
      end else if (step) begin
        if (wdata_vld) wshift <= {wdata, wshift[31:1]};
        if (rdata_rdy) rshift <= {1'b0, rshift[31:1]};
        if (cnt != 6'd0) cnt <= cnt - 6'd1;
      end
      if (addr_we) addr <= addr_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags (sets take priority over a CSR clear)
  // ---------------------------------------------------------------------------
  always_ff @(posedge dck) begin
    if (drst) begin
      parerr  <= 1'b0;
      unkcmd  <= 1'b0;
      buserr  <= 1'b0;
      busyerr <= 1'b0;
    end else begin
      if (csr_we && wshift[25]) begin
        parerr  <= 1'b0;
        unkcmd  <= 1'b0;
        buserr  <= 1'b0;
        busyerr <= 1'b0;
      end
      if (parity_err)                    parerr  <= 1'b1;
      if (unk_set)                       unkcmd  <= 1'b1;
      if (busy_set)                      busyerr <= 1'b1;
      if (bus_req && bus_ack && bus_err) buserr  <= 1'b1;
    end
  end

`ifdef DTM_PAYLOAD_AUTO_INCR_EN
  // CSR byte sits in wshift[31:24]; bit0 is AINCR.
  always_ff @(posedge dck) begin
    if (drst)        aincr <= 1'b0;
    else if (csr_we) aincr <= wshift[24];
  end
`else
  assign aincr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus master: one outstanding access; a launch in the ack cycle chains
  // straight into the next request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge dck) begin
    if (drst) begin
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rbuf      <= '0;
    end else begin
      if (bus_req && bus_ack) begin
        bus_req <= 1'b0;
        if (!bus_write) rbuf <= bus_rdata;
      end
      if (launch) begin
        bus_req   <= 1'b1;
        bus_write <= launch_write;
        bus_addr  <= launch_addr;
        if (launch_write) bus_wdata <= wshift;
      end
    end
  end

endmodule

// File: tb/tb_twowire_dtm_payload_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_twowire_dtm_payload_ctrl
//
// Directed bench for twowire_dtm_payload_ctrl. A transaction-level model tracks
// the programmer-visible state (address, read buffer, flags, pending bus access).
// One compare process checks the bus outputs, cmd_payload_end and rdata against
// the model on every falling edge. The main sequence also pins key values with
// hand-computed literals. Honours DTM_PAYLOAD_AUTO_INCR_EN the same way the
// design does.
// -----------------------------------------------------------------------------
module tb_twowire_dtm_payload_ctrl;

  localparam int W_CMD  = 4;
  localparam int W_ADDR = 32;
`ifdef DTM_PAYLOAD_AUTO_INCR_EN
  localparam bit AINC = 1'b1;
`else
  localparam bit AINC = 1'b0;
`endif

  logic              dck = 1'b0;
  logic              drst;
  logic              connected;
  logic [W_CMD-1:0]  cmd;
  logic              cmd_vld;
  logic              cmd_payload_end;
  logic              parity_err;
  logic              wdata;
  logic              wdata_vld;
  logic              rdata;
  logic              rdata_rdy;
  logic              bus_req;
  logic              bus_write;
  logic [W_ADDR-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              bus_err;

  twowire_dtm_payload_ctrl #(.W_CMD(W_CMD), .W_ADDR(W_ADDR)) dut (
    .dck(dck), .drst(drst), .connected(connected), .cmd(cmd), .cmd_vld(cmd_vld),
    .cmd_payload_end(cmd_payload_end), .parity_err(parity_err), .wdata(wdata),
    .wdata_vld(wdata_vld), .rdata(rdata), .rdata_rdy(rdata_rdy), .bus_req(bus_req),
    .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 dck = ~dck;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- model ----------------
  logic [31:0] m_addr, m_rbuf, m_baddr, m_bwdata;
  bit          m_req, m_write, m_aincr, m_parerr, m_unk, m_buserr, m_busyerr;

  // Per-cycle expectations published by the stimulus tasks
  bit chk_on    = 1'b0;
  bit exp_end   = 1'b0;
  bit exp_rd_on = 1'b0;
  bit exp_rbit  = 1'b0;

  function automatic void model_reset();
    m_addr = 0; m_rbuf = 0; m_baddr = 0; m_bwdata = 0;
    m_req = 0; m_write = 0; m_aincr = 0;
    m_parerr = 0; m_unk = 0; m_buserr = 0; m_busyerr = 0;
  endfunction

  function automatic logic [7:0] m_stat();
    return {2'b00, m_parerr, m_unk, m_aincr, m_buserr, m_busyerr, m_req};
  endfunction

  function automatic int plen(input logic [3:0] c);
    case (c)
      4'h1, 4'h6: return 8;
      4'h2, 4'h3: return W_ADDR;
      4'h4, 4'h5: return 32;
      default:    return 1;
    endcase
  endfunction

  function automatic void m_launch(input bit w, input logic [31:0] a, input logic [31:0] d);
    m_req = 1; m_write = w; m_baddr = a;
    if (w) m_bwdata = d;
  endfunction

  // Effect of a completed command (v = payload value, right-aligned)
  function automatic void model_commit(input logic [3:0] c, input logic [31:0] v, input bit pb);
    if (pb) begin
      m_parerr = 1;
      return;
    end
    case (c)
      4'h3: if (!m_req) begin m_addr = v; m_launch(0, m_addr, 0); end else m_busyerr = 1;
      4'h5: if (!m_req) begin
              m_launch(1, m_addr, v);
              if (m_aincr) m_addr = m_addr + 4;
            end else m_busyerr = 1;
      4'h4: if (!m_req) begin
              if (m_aincr) m_addr = m_addr + 4;
              m_launch(0, m_addr, 0);
            end else m_busyerr = 1;
      4'h6: begin
              if (AINC) m_aincr = v[0];
              if (v[1]) begin m_parerr = 0; m_unk = 0; m_buserr = 0; m_busyerr = 0; end
            end
      4'h1, 4'h2: ;
      default: m_unk = 1;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge dck) begin
    if (chk_on) begin
      chk("bus_req", {31'd0, bus_req}, {31'd0, m_req});
      if (m_req) begin
        chk("bus_write", {31'd0, bus_write}, {31'd0, m_write});
        chk("bus_addr", bus_addr, m_baddr);
        if (m_write) chk("bus_wdata", bus_wdata, m_bwdata);
      end
      chk("payload_end", {31'd0, cmd_payload_end}, {31'd0, exp_end});
      if (exp_rd_on) chk("rdata_bit", {31'd0, rdata}, {31'd0, exp_rbit});
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic send_cmd(input logic [3:0] c);
    cmd = c; cmd_vld = 1;
    @(posedge dck); #1;
    cmd_vld = 0;
  endtask

  task automatic do_write(input logic [3:0] c, input logic [31:0] v, input bit pb);
    int n;
    n = plen(c);
    send_cmd(c);
    for (int i = 0; i < n; i++) begin
      wdata = v[i]; wdata_vld = 1; exp_end = (i == n - 1);
      @(posedge dck); #1;
    end
    wdata_vld = 0; exp_end = 0; parity_err = pb;
    @(posedge dck); #1;
    parity_err = 0;
    model_commit(c, v, pb);
  endtask

  task automatic do_read(input logic [3:0] c, output logic [31:0] got);
    int n;
    logic [31:0] ev;
    n = plen(c);
    case (c)
      4'h1:    ev = 32'(m_stat());
      4'h2:    ev = m_addr;
      4'h4:    ev = m_rbuf;
      default: ev = 0;
    endcase
    send_cmd(c);
    got = 0;
    for (int i = 0; i < n; i++) begin
      rdata_rdy = 1; exp_rd_on = 1; exp_rbit = ev[i]; exp_end = (i == n - 1);
      @(negedge dck);
      got[i] = rdata;
      @(posedge dck); #1;
    end
    rdata_rdy = 0; exp_rd_on = 0; exp_end = 0;
    @(posedge dck); #1;
    model_commit(c, 0, 0);
  endtask

  task automatic ack(input logic [31:0] rd, input bit err);
    bus_ack = 1; bus_rdata = rd; bus_err = err;
    @(posedge dck); #1;
    bus_ack = 0; bus_err = 0;
    if (m_req) begin
      if (!m_write) m_rbuf = rd;
      if (err) m_buserr = 1;
      m_req = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus_req"},   {31'd0, bus_req}, 0);
    chk({tag, "_bus_write"}, {31'd0, bus_write}, 0);
    chk({tag, "_bus_addr"},  bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_rdata"},     {31'd0, rdata}, 0);
    chk({tag, "_pend"},      {31'd0, cmd_payload_end}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    drst = 1; connected = 1; cmd = 0; cmd_vld = 0; parity_err = 0;
    wdata = 0; wdata_vld = 0; rdata_rdy = 0; bus_ack = 0; bus_rdata = 0; bus_err = 0;
    model_reset();
    repeat (3) @(posedge dck);
    #1;
    drst = 0;
    check_reset_outputs("rst");
    chk_on = 1;
    do_read(4'h1, got); chk("rst_stat", got, 32'h00);
    do_read(4'h2, got); chk("rst_addr", got, 32'h0);

    // W_ADDR -> prefetch, then R_DATA shifts out the prefetched word
    do_write(4'h3, 32'h0000_1000, 0);
    chk("waddr_req",   {31'd0, bus_req}, 1);
    chk("waddr_write", {31'd0, bus_write}, 0);
    chk("waddr_addr",  bus_addr, 32'h0000_1000);
    ack(32'hCAFE_F00D, 0);
    do_read(4'h4, got); chk("rdata_word", got, 32'hCAFE_F00D);
    chk("rdata_relaunch", bus_addr, 32'h0000_1000);
    ack(32'h5555_AAAA, 0);

    // AINCR on, two writes
    do_write(4'h3, 32'h0000_1000, 0);
    ack(32'h600D_D00D, 0);
    do_write(4'h6, 32'h01, 0);
    do_write(4'h5, 32'h1234_5678, 0);
    chk("wr1_write", {31'd0, bus_write}, 1);
    chk("wr1_addr",  bus_addr, 32'h0000_1000);
    chk("wr1_data",  bus_wdata, 32'h1234_5678);
    ack(0, 0);
    do_write(4'h5, 32'h1234_5678, 0);
    chk("wr2_addr", bus_addr, AINC ? 32'h0000_1004 : 32'h0000_1000);
    ack(0, 0);
    do_read(4'h2, got); chk("addr_after_wr", got, AINC ? 32'h0000_1008 : 32'h0000_1000);

    // Busy: second W_DATA and R_DATA are refused
    do_write(4'h6, 32'h02, 0);
    do_write(4'h5, 32'hA5A5_0001, 0);
    do_write(4'h5, 32'h0BAD_0BAD, 0);
    chk("busy_wdata_kept", bus_wdata, 32'hA5A5_0001);
    do_read(4'h1, got); chk("busy_stat", got, 32'h03);
    do_read(4'h4, got); chk("busy_stale_rbuf", got, 32'h600D_D00D);
    ack(0, 1);
    do_read(4'h1, got); chk("buserr_stat", got, 32'h06);

    // Parity error in the check cycle blocks W_ADDR
    do_write(4'h6, 32'h02, 0);
    do_write(4'h3, 32'h0000_2000, 1);
    chk("par_no_req", {31'd0, bus_req}, 0);
    do_read(4'h1, got); chk("par_stat", got, 32'h20);
    do_read(4'h2, got); chk("par_addr", got, AINC ? 32'h0000_1008 : 32'h0000_1000);

    // Unknown command: 1-bit payload, UNKCMD, cleared by W_CSR
    do_write(4'h6, 32'h02, 0);
    do_write(4'hF, 32'h1, 0);
    do_read(4'h1, got); chk("unk_stat", got, 32'h10);
    do_write(4'h6, 32'h02, 0);
    do_read(4'h1, got); chk("clr_stat", got, 32'h00);

    // Link drop mid-payload: no commit
    send_cmd(4'h3);
    for (int i = 0; i < 5; i++) begin
      wdata = 1; wdata_vld = 1;
      @(posedge dck); #1;
    end
    wdata_vld = 0; connected = 0;
    @(posedge dck); #1;
    connected = 1;
    chk("disc_no_req", {31'd0, bus_req}, 0);
    do_read(4'h2, got); chk("disc_addr", got, AINC ? 32'h0000_1008 : 32'h0000_1000);

    // Address wrap on auto-increment
    do_write(4'h3, 32'hFFFF_FFFC, 0);
    chk("wrap_prefetch", bus_addr, 32'hFFFF_FFFC);
    ack(32'h0000_1234, 0);
    do_write(4'h6, 32'h01, 0);
    do_read(4'h4, got); chk("wrap_rdata", got, 32'h0000_1234);
    chk("wrap_addr", bus_addr, AINC ? 32'h0000_0000 : 32'hFFFF_FFFC);
    ack(0, 0);
    do_read(4'h2, got); chk("wrap_reg", got, AINC ? 32'h0000_0000 : 32'hFFFF_FFFC);

    // Reset in the middle of a payload with a bus access pending
    do_write(4'h5, 32'hDEAD_BEEF, 0);
    send_cmd(4'h5);
    for (int i = 0; i < 10; i++) begin
      wdata = i[0]; wdata_vld = 1;
      @(posedge dck); #1;
    end
    chk_on = 0;
    wdata_vld = 0; drst = 1;
    @(posedge dck); #1;
    drst = 0;
    model_reset();
    check_reset_outputs("midrst");
    chk_on = 1;
    do_read(4'h1, got); chk("midrst_stat", got, 32'h00);
    do_read(4'h2, got); chk("midrst_addr", got, 32'h0);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
